// File: rtl/matmul_operand_feeder_if.sv
// ----------------------------------------------------------------------------
// matmul_operand_feeder_if
// Bundles every non-clock/reset signal of matmul_operand_feeder:
//   job control   : go_i, mode_i, n/k/m_dim_i, busy_o, done_o
//   scratchpad    : rd_en_o, rd_addr_o (out), rd_data_i (in, latency 1)
//   calc stage    : start_o, mode_o, n/k/m_dim_o, data_a/b/c_o (out),
//                   finish_mul_i (in)
// Modport master is the feeder itself; modport slave is its environment.
// ----------------------------------------------------------------------------
interface matmul_operand_feeder_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
);
    logic                  go_i;
    logic                  mode_i;
    logic [1:0]            n_dim_i;
    logic [1:0]            k_dim_i;
    logic [1:0]            m_dim_i;
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [BUS_WIDTH-1:0]  rd_data_i;
    logic                  start_o;
    logic                  mode_o;
    logic [1:0]            n_dim_o;
    logic [1:0]            k_dim_o;
    logic [1:0]            m_dim_o;
    logic [BUS_WIDTH-1:0]  data_a_o;
    logic [BUS_WIDTH-1:0]  data_b_o;
    logic [BUS_WIDTH-1:0]  data_c_o;
    logic                  finish_mul_i;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        input  go_i, mode_i, n_dim_i, k_dim_i, m_dim_i, rd_data_i, finish_mul_i,
        output rd_en_o, rd_addr_o, start_o, mode_o, n_dim_o, k_dim_o, m_dim_o,
               data_a_o, data_b_o, data_c_o, busy_o, done_o
    );

    modport slave (
        output go_i, mode_i, n_dim_i, k_dim_i, m_dim_i, rd_data_i, finish_mul_i,
        input  rd_en_o, rd_addr_o, start_o, mode_o, n_dim_o, k_dim_o, m_dim_o,
               data_a_o, data_b_o, data_c_o, busy_o, done_o
    );
endinterface

// File: rtl/matmul_operand_feeder.sv
// ----------------------------------------------------------------------------
// matmul_operand_feeder
// Upstream stage of the matmul calc block. On go it reads the A rows, B rows
// and (mode=1) the C bias words through a latency-1 scratchpad read port,
// buffers them, then streams A/B/C in parallel with start_o high. start_o is
// released after the calc stage reports finish_mul_i, followed by a one-cycle
// done_o.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (aborts a job, no done_o)
//   bus    : matmul_operand_feeder_if.master (control, scratchpad, calc side)
// Address format: [4:0] operand select, [5 +: 2*clog2(MAX_DIM)] index.
// ----------------------------------------------------------------------------
module matmul_operand_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    matmul_operand_feeder_if.master bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int NELEM   = MAX_DIM * MAX_DIM;
    localparam int ROW_W   = $clog2(MAX_DIM);
    localparam int IDX_W   = 2 * ROW_W;
    // one spare bit so counters reach MAX_DIM*MAX_DIM without wrapping
    localparam int CNT_W   = IDX_W + 1;

    localparam logic [CNT_W-1:0] LAST_J  = CNT_W'(NELEM - 1);
    localparam logic [1:0]       DIM_MAX = 2'(MAX_DIM - 1);
    localparam logic [4:0]       SEL_A   = 5'b00100;
    localparam logic [4:0]       SEL_B   = 5'b01000;
    localparam logic [4:0]       SEL_C   = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_DRAIN, S_STREAM, S_WAIT, S_DONE
    } state_t;

    typedef enum logic [1:0] {OP_A, OP_B, OP_C} op_t;

    function automatic logic [1:0] sat_dim(input logic [1:0] d);
        if (int'(d) > MAX_DIM - 1) return DIM_MAX;
        return d;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [4:0] sel,
                                                        input logic [IDX_W-1:0] idx);
        logic [ADDR_WIDTH-1:0] a;
        a              = '0;
        a[4:0]         = sel;
        a[5 +: IDX_W]  = idx;
        return a;
    endfunction

    state_t                             state_q, state_d;
    logic [CNT_W-1:0]                   idx_q, idx_d;
    logic                               rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]              rd_addr_q, rd_addr_d;
    logic                               tag_vld_q, tag_vld_d;
    op_t                                tag_op_q, tag_op_d;
    logic [IDX_W-1:0]                   tag_idx_q, tag_idx_d;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  a_buf_q, a_buf_d;
    logic [MAX_DIM-1:0][BUS_WIDTH-1:0]  b_buf_q, b_buf_d;
    logic [NELEM-1:0][BUS_WIDTH-1:0]    c_buf_q, c_buf_d;
    logic                               mode_q, mode_d;
    logic [1:0]                         n_q, n_d, k_q, k_d, m_q, m_d;
    logic                               start_q, start_d;
    logic [BUS_WIDTH-1:0]               data_a_q, data_a_d;
    logic [BUS_WIDTH-1:0]               data_b_q, data_b_d;
    logic [BUS_WIDTH-1:0]               data_c_q, data_c_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               fin_seen_q, fin_seen_d;

    logic [CNT_W-1:0] n_ext, m_ext, c_last, idx_inc, sel_j;
    logic             show;

    assign n_ext   = CNT_W'(n_q);
    assign m_ext   = CNT_W'(m_q);
    assign c_last  = (n_ext + CNT_W'(1)) * (m_ext + CNT_W'(1)) - CNT_W'(1);
    assign idx_inc = idx_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = '0;
        tag_vld_d  = rd_en_q;
        tag_idx_d  = idx_q[IDX_W-1:0];
        tag_op_d   = OP_A;
        a_buf_d    = a_buf_q;
        b_buf_d    = b_buf_q;
        c_buf_d    = c_buf_q;
        mode_d     = mode_q;
        n_d        = n_q;
        k_d        = k_q;
        m_d        = m_q;
        start_d    = start_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fin_seen_d = fin_seen_q;
        data_a_d   = '0;
        data_b_d   = '0;
        data_c_d   = '0;
        show       = 1'b0;
        sel_j      = '0;

        if (state_q == S_LOAD_B) tag_op_d = OP_B;
        if (state_q == S_LOAD_C) tag_op_d = OP_C;

        // the tag issued with a read lands the returning word one cycle later
        if (tag_vld_q) begin
            case (tag_op_q)
                OP_A:    a_buf_d[tag_idx_q[ROW_W-1:0]] = bus.rd_data_i;
                OP_B:    b_buf_d[tag_idx_q[ROW_W-1:0]] = bus.rd_data_i;
                default: c_buf_d[tag_idx_q]            = bus.rd_data_i;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (bus.go_i) begin
                    state_d    = S_LOAD_A;
                    idx_d      = '0;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = make_addr(SEL_A, '0);
                    mode_d     = bus.mode_i;
                    n_d        = sat_dim(bus.n_dim_i);
                    k_d        = sat_dim(bus.k_dim_i);
                    m_d        = sat_dim(bus.m_dim_i);
                    a_buf_d    = '0;
                    b_buf_d    = '0;
                    c_buf_d    = '0;
                    busy_d     = 1'b1;
                    fin_seen_d = 1'b0;
                end
            end
            S_LOAD_A: begin
                rd_en_d = 1'b1;
                if (idx_q == n_ext) begin
                    state_d   = S_LOAD_B;
                    idx_d     = '0;
                    rd_addr_d = make_addr(SEL_B, '0);
                end else begin
                    idx_d     = idx_inc;
                    rd_addr_d = make_addr(SEL_A, idx_inc[IDX_W-1:0]);
                end
            end
            S_LOAD_B: begin
                if (idx_q == m_ext) begin
                    if (mode_q) begin
                        state_d   = S_LOAD_C;
                        idx_d     = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = make_addr(SEL_C, '0);
                    end else begin
                        state_d   = S_DRAIN;
                    end
                end else begin
                    idx_d     = idx_inc;
                    rd_en_d   = 1'b1;
                    rd_addr_d = make_addr(SEL_B, idx_inc[IDX_W-1:0]);
                end
            end
            S_LOAD_C: begin
                if (idx_q == c_last) begin
                    state_d   = S_DRAIN;
                end else begin
                    idx_d     = idx_inc;
                    rd_en_d   = 1'b1;
                    rd_addr_d = make_addr(SEL_C, idx_inc[IDX_W-1:0]);
                end
            end
            S_DRAIN: begin
                state_d = S_STREAM;
                start_d = 1'b1;
                idx_d   = '0;
                show    = 1'b1;
                sel_j   = '0;
            end
            S_STREAM: begin
                // an early finish is remembered so WAIT lasts a single cycle
                fin_seen_d = fin_seen_q | bus.finish_mul_i;
                if (idx_q == LAST_J) begin
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_inc;
                    show  = 1'b1;
                    sel_j = idx_inc;
                end
            end
            S_WAIT: begin
                if (bus.finish_mul_i || fin_seen_q) begin
                    state_d = S_DONE;
                    start_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // stream from the next-state buffers so the word captured in DRAIN is visible
        if (show) begin
            if (sel_j <= n_ext)            data_a_d = a_buf_d[sel_j[ROW_W-1:0]];
            if (sel_j <= m_ext)            data_b_d = b_buf_d[sel_j[ROW_W-1:0]];
            if (mode_q && sel_j <= c_last) data_c_d = c_buf_d[sel_j[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            tag_vld_q  <= 1'b0;
            tag_op_q   <= OP_A;
            tag_idx_q  <= '0;
            a_buf_q    <= '0;
            b_buf_q    <= '0;
            c_buf_q    <= '0;
            mode_q     <= 1'b0;
            n_q        <= '0;
            k_q        <= '0;
            m_q        <= '0;
            start_q    <= 1'b0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            data_c_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fin_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            tag_vld_q  <= tag_vld_d;
            tag_op_q   <= tag_op_d;
            tag_idx_q  <= tag_idx_d;
            a_buf_q    <= a_buf_d;
            b_buf_q    <= b_buf_d;
            c_buf_q    <= c_buf_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            k_q        <= k_d;
            m_q        <= m_d;
            start_q    <= start_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            data_c_q   <= data_c_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fin_seen_q <= fin_seen_d;
        end
    end

    assign bus.rd_en_o   = rd_en_q;
    assign bus.rd_addr_o = rd_addr_q;
    assign bus.start_o   = start_q;
    assign bus.mode_o    = mode_q;
    assign bus.n_dim_o   = n_q;
    assign bus.k_dim_o   = k_q;
    assign bus.m_dim_o   = m_q;
    assign bus.data_a_o  = data_a_q;
    assign bus.data_b_o  = data_b_q;
    assign bus.data_c_o  = data_c_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
endmodule

// File: tb/tb_matmul_operand_feeder.sv
`timescale 1ns/1ps
module tb_matmul_operand_feeder;
    localparam int DW  = 8;
    localparam int BW  = 16;
    localparam int AW  = 32;
    localparam int NEL = 4;

    typedef struct packed {
        logic          rd_en;
        logic [AW-1:0] addr;
        logic          start;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] c;
        logic          done;
        logic          busy;
        logic          mode;
        logic [1:0]    n;
        logic [1:0]    k;
        logic [1:0]    m;
    } obs_t;

    typedef struct {
        logic       mode;
        logic [1:0] n;
        logic [1:0] k;
        logic [1:0] m;
        int         fin_off;
        logic       hold;
        logic       spec_data;
        int         exp_reads;
        int         exp_start;
        logic [1:0] exp_n;
        logic [1:0] exp_k;
        logic [1:0] exp_m;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [BW-1:0] mem [128];
    obs_t trace [64];

    always #5 clk = ~clk;

    matmul_operand_feeder_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    matmul_operand_feeder #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // latency-1 scratchpad
    always @(posedge clk) bus.rd_data_i <= mem[bus.rd_addr_o[6:0]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.rd_en = bus.rd_en_o;
        o.addr  = bus.rd_addr_o;
        o.start = bus.start_o;
        o.a     = bus.data_a_o;
        o.b     = bus.data_b_o;
        o.c     = bus.data_c_o;
        o.done  = bus.done_o;
        o.busy  = bus.busy_o;
        o.mode  = bus.mode_o;
        o.n     = bus.n_dim_o;
        o.k     = bus.k_dim_o;
        o.m     = bus.m_dim_o;
        return o;
    endfunction

    function automatic logic [BW-1:0] mem_at(input int sel, input int j);
        return mem[7'(sel + 32 * j)];
    endfunction

    // Reference: reads listed per operand, cycle 0 is the go cycle, loads from
    // cycle 1, one drain cycle, NEL stream cycles, then wait for finish.
    task automatic run_job(input vec_t v, input bit use_tbl, input string tag);
        int ns, ks, ms, nc, r, s, fc, d, j, nreads, first_start;
        logic [AW-1:0] rd_q[$];
        obs_t e, o;
        for (int i = 0; i < 128; i++) mem[i] = BW'($urandom);
        if (v.spec_data) begin
            mem[7'h04] = 16'h0201; mem[7'h24] = 16'h0403;
            mem[7'h08] = 16'h0605; mem[7'h28] = 16'h0807;
            mem[7'h10] = 16'd1; mem[7'h30] = 16'd2; mem[7'h50] = 16'd3; mem[7'h70] = 16'd4;
        end
        ns = (v.n > 2'd1) ? 1 : int'(v.n);
        ks = (v.k > 2'd1) ? 1 : int'(v.k);
        ms = (v.m > 2'd1) ? 1 : int'(v.m);
        nc = v.mode ? (ns + 1) * (ms + 1) : 0;
        for (int i = 0; i <= ns; i++) rd_q.push_back(AW'(32'h04 + 32 * i));
        for (int i = 0; i <= ms; i++) rd_q.push_back(AW'(32'h08 + 32 * i));
        for (int i = 0; i < nc; i++)  rd_q.push_back(AW'(32'h10 + 32 * i));
        r  = rd_q.size();
        s  = r + 2;
        fc = s + NEL + v.fin_off;
        d  = ((fc > s + NEL) ? fc : s + NEL) + 1;
        nreads = 0;
        first_start = -1;

        @(negedge clk);
        bus.go_i    = 1'b1;
        bus.mode_i  = v.mode;
        bus.n_dim_i = v.n;
        bus.k_dim_i = v.k;
        bus.m_dim_i = v.m;
        for (int c = 1; c <= d + 2; c++) begin
            @(negedge clk);
            o = sample();
            e = '0;
            if (c <= r) begin
                e.rd_en = 1'b1;
                e.addr  = rd_q[c-1];
            end
            e.start = (c >= s) && (c < d);
            j = c - s;
            if (j >= 0 && j < NEL) begin
                e.a = (j <= ns) ? mem_at(32'h04, j) : '0;
                e.b = (j <= ms) ? mem_at(32'h08, j) : '0;
                e.c = (v.mode && j < nc) ? mem_at(32'h10, j) : '0;
            end
            e.done = (c == d);
            e.busy = (c <= d);
            e.mode = v.mode;
            e.n    = 2'(ns);
            e.k    = 2'(ks);
            e.m    = 2'(ms);
            chk($sformatf("%s cyc%0d", tag, c), 128'(o), 128'(e));
            if (o.rd_en) nreads++;
            if (o.start && first_start < 0) first_start = c;
            if (c < 64) trace[c] = o;
            bus.go_i         = v.hold && (c <= d);
            bus.finish_mul_i = (c == fc);
        end
        bus.go_i         = 1'b0;
        bus.finish_mul_i = 1'b0;

        if (use_tbl) begin
            chk({tag, " nreads"},    128'(nreads),      128'(v.exp_reads));
            chk({tag, " start_cyc"}, 128'(first_start), 128'(v.exp_start));
            chk({tag, " dims"}, 128'({trace[1].n, trace[1].k, trace[1].m}),
                128'({v.exp_n, v.exp_k, v.exp_m}));
        end
        if (v.spec_data) begin
            chk("spec c10", 128'({trace[10].a, trace[10].b, trace[10].c}), 128'({16'h0201, 16'h0605, 16'd1}));
            chk("spec c11", 128'({trace[11].a, trace[11].b, trace[11].c}), 128'({16'h0403, 16'h0807, 16'd2}));
            chk("spec c12", 128'({trace[12].a, trace[12].b, trace[12].c}), 128'({16'h0000, 16'h0000, 16'd3}));
            chk("spec c13", 128'({trace[13].a, trace[13].b, trace[13].c}), 128'({16'h0000, 16'h0000, 16'd4}));
        end
    endtask

    task automatic reset_abort();
        obs_t o;
        for (int i = 0; i < 128; i++) mem[i] = BW'($urandom);
        @(negedge clk);
        bus.go_i    = 1'b1;
        bus.mode_i  = 1'b1;
        bus.n_dim_i = 2'd1;
        bus.k_dim_i = 2'd1;
        bus.m_dim_i = 2'd1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            o = sample();
            if (c == 3) chk("rst_in_load_b", 128'({o.rd_en, o.addr}), 128'({1'b1, 32'h08}));
            if (c >= 4) chk($sformatf("rst_abort cyc%0d", c), 128'(o), 128'(0));
            bus.go_i = 1'b0;
            rst = (c == 3) || (c == 4);
        end
    endtask

    initial begin
        vec_t tbl [5];
        vec_t rv;
        bus.go_i         = 1'b0;
        bus.mode_i       = 1'b0;
        bus.n_dim_i      = '0;
        bus.k_dim_i      = '0;
        bus.m_dim_i      = '0;
        bus.finish_mul_i = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 128'(sample()), 128'(0));
        rst = 1'b0;

        //        mode  n     k     m     fin  hold  spec  reads start  n_o   k_o   m_o
        tbl[0] = '{1'b1, 2'd1, 2'd1, 2'd1,  5, 1'b0, 1'b1, 8,    10,   2'd1, 2'd1, 2'd1};
        tbl[1] = '{1'b0, 2'd0, 2'd0, 2'd0,  0, 1'b0, 1'b0, 2,    4,    2'd0, 2'd0, 2'd0};
        tbl[2] = '{1'b0, 2'd3, 2'd2, 2'd0, -2, 1'b0, 1'b0, 3,    5,    2'd1, 2'd1, 2'd0};
        tbl[3] = '{1'b1, 2'd0, 2'd1, 2'd1,  1, 1'b0, 1'b0, 5,    7,    2'd0, 2'd1, 2'd1};
        tbl[4] = '{1'b1, 2'd1, 2'd3, 2'd0,  3, 1'b1, 1'b0, 5,    7,    2'd1, 2'd1, 2'd0};
        for (int i = 0; i < 5; i++) run_job(tbl[i], 1'b1, $sformatf("vec%0d", i));

        reset_abort();

        for (int i = 0; i < 8; i++) begin
            rv.mode      = 1'($urandom_range(0, 1));
            rv.n         = 2'($urandom_range(0, 3));
            rv.k         = 2'($urandom_range(0, 3));
            rv.m         = 2'($urandom_range(0, 3));
            rv.fin_off   = int'($urandom_range(0, 9)) - 3;
            rv.hold      = 1'($urandom_range(0, 1));
            rv.spec_data = 1'b0;
            rv.exp_reads = 0;
            rv.exp_start = 0;
            rv.exp_n     = '0;
            rv.exp_k     = '0;
            rv.exp_m     = '0;
            run_job(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
